alu_kontrol: RTL

ALU_KONTROL -- requirements
Module: alu_kontrol

---
 rtl/alu_kontrol.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_kontrol.sv
// Multi-cycle controller around an external combinational ALU with a 4x8 register file.
// Each request takes four cycles (accept, read operands, compute, write back); new requests only accepted when idle.
module alu_kontrol (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       istek_in,
  output logic       hazir_out,
  input  logic [2:0] islem_in,
  input  logic [1:0] hedef_in,
  input  logic [1:0] kaynak1_in,
  input  logic [1:0] kaynak2_in,
  input  logic       anlik_sec_in,
  input  logic [7:0] veri_in,
  output logic [2:0] alu_islem_out,
  output logic [7:0] alu_s1_out,
  output logic [7:0] alu_s2_out,
  input  logic [7:0] alu_s_in,
  output logic [7:0] sonuc_out,
  output logic       gecerli_out,
  output logic       sifir_out,
  input  logic [1:0] oku_adr_in,
  output logic [7:0] oku_veri_out
);

  typedef enum logic [1:0] {BOSTA = 2'd0, OKU = 2'd1, HESAPLA = 2'd2, YAZ = 2'd3} durum_t;

  durum_t     r_durum;
  durum_t     w_sonraki;

  logic [2:0] r_islem;
  logic [1:0] r_hedef;
  logic [1:0] r_k1;
  logic [1:0] r_k2;
  logic       r_anlik;
  logic [7:0] r_veri;

  logic [2:0] r_alu_islem;
  logic [7:0] r_alu_s1;
  logic [7:0] r_alu_s2;
  logic [7:0] r_sonuc;
  logic       r_sifir;
  logic [7:0] r_dosya [4];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_durum <= BOSTA;
    else           r_durum <= w_sonraki;
  end

  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOSTA:   if (istek_in) w_sonraki = OKU;
      OKU:     w_sonraki = HESAPLA;
      HESAPLA: w_sonraki = YAZ;
      YAZ:     w_sonraki = BOSTA;
      default: w_sonraki = BOSTA;
    endcase
  end

  // The ALU operand registers double as the ALU drive, so they hold between operations.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_islem     <= 3'd0;
      r_hedef     <= 2'd0;
      r_k1        <= 2'd0;
      r_k2        <= 2'd0;
      r_anlik     <= 1'b0;
      r_veri      <= 8'h00;
      r_alu_islem <= 3'd0;
      r_alu_s1    <= 8'h00;
      r_alu_s2    <= 8'h00;
      r_sonuc     <= 8'h00;
      r_sifir     <= 1'b0;
      for (int i = 0; i < 4; i++) r_dosya[i] <= 8'h00;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (istek_in) begin
            r_islem <= islem_in;
            r_hedef <= hedef_in;
            r_k1    <= kaynak1_in;
            r_k2    <= kaynak2_in;
            r_anlik <= anlik_sec_in;
            r_veri  <= veri_in;
          end
        end
        OKU: begin
          r_alu_islem <= r_islem;
          r_alu_s1    <= r_dosya[r_k1];
          r_alu_s2    <= r_anlik ? r_veri : r_dosya[r_k2];
        end
        HESAPLA: begin
          r_sonuc <= alu_s_in;
          r_sifir <= (alu_s_in == 8'h00);
        end
        YAZ: begin
          r_dosya[r_hedef] <= r_sonuc;
        end
        default: ;
      endcase
    end
  end

  assign hazir_out     = (r_durum == BOSTA);
  assign gecerli_out   = (r_durum == YAZ);
  assign alu_islem_out = r_alu_islem;
  assign alu_s1_out    = r_alu_s1;
  assign alu_s2_out    = r_alu_s2;
  assign sonuc_out     = r_sonuc;
  assign sifir_out     = r_sifir;
  assign oku_veri_out  = r_dosya[oku_adr_in];

endmodule
